// File: rtl/decode_sequencer.sv
// ID-stage decode/sequencer: opcode -> immediate format select, registered toward EX,
// with fixed-latency divide sequencing. Optional macro ILLEGAL_DETECT_EN builds illegal-opcode flagging.
module decode_sequencer #(
    parameter int DIV_LATENCY = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION_IN,
    input  logic        VALID_IN,
    output logic        READY_OUT,
    input  logic        FLUSH,
    input  logic        READY_IN,
    output logic        VALID_OUT,
    output logic [31:0] INSTRUCTION_OUT,
    output logic [3:0]  IMM_SELECT,
    output logic        IS_MULDIV,
    output logic        DIV_START,
    output logic        DIV_KILL,
    output logic        ILLEGAL_OUT
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [5:0] CNT_INIT  = 6'(DIV_LATENCY - 1);

    typedef enum logic {ST_RUN, ST_DIV_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_div_start, w_start_nxt;
    logic        r_div_kill, w_kill_nxt;
    logic [31:0] r_instr;
    logic [3:0]  r_imm;
    logic        r_muldiv;
    logic        w_load;
    logic        w_accept;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [3:0]  w_imm_sel;
    logic        w_is_muldiv;
    logic        w_is_div;

    assign w_opcode = INSTRUCTION_IN[6:0];
    assign w_funct3 = INSTRUCTION_IN[14:12];

    always_comb begin
        w_imm_sel = 4'b0111;
        case (w_opcode)
            OP_LUI, OP_AUIPC:  w_imm_sel = 4'b0000;
            OP_JAL:            w_imm_sel = 4'b0001;
            OP_IMM:            w_imm_sel = (w_funct3[1:0] == 2'b01) ? 4'b0101 : 4'b0010;
            OP_LOAD, OP_JALR:  w_imm_sel = 4'b0010;
            OP_BRANCH:         w_imm_sel = 4'b0011;
            OP_STORE:          w_imm_sel = 4'b0100;
            default:           w_imm_sel = 4'b0111;
        endcase
    end

    assign w_is_muldiv = (w_opcode == OP_REG) && (INSTRUCTION_IN[31:25] == 7'b0000001);
    assign w_is_div    = w_is_muldiv && w_funct3[2];

    // Nothing is accepted while a divide is outstanding.
    assign READY_OUT = (r_state == ST_RUN) && (READY_IN || !r_valid);
    assign w_accept  = VALID_IN && READY_OUT;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_valid;
        w_start_nxt = 1'b0;
        w_kill_nxt  = 1'b0;
        w_load      = 1'b0;
        if (FLUSH) begin
            w_kill_nxt  = (r_state == ST_DIV_WAIT) || r_div_start;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 6'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        w_load = 1'b1;
                        if (w_is_div) begin
                            w_valid_nxt = 1'b0;
                            w_start_nxt = 1'b1;
                            w_cnt_nxt   = CNT_INIT;
                            w_state_nxt = ST_DIV_WAIT;
                        end else begin
                            w_valid_nxt = 1'b1;
                        end
                    end else begin
                        w_valid_nxt = r_valid && !READY_IN;
                    end
                end
                ST_DIV_WAIT: begin
                    if (r_cnt == 6'd0) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 6'd1;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_RUN;
            r_cnt       <= 6'd0;
            r_valid     <= 1'b0;
            r_div_start <= 1'b0;
            r_div_kill  <= 1'b0;
            r_instr     <= 32'h00000013;
            r_imm       <= 4'b0111;
            r_muldiv    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_valid     <= w_valid_nxt;
            r_div_start <= w_start_nxt;
            r_div_kill  <= w_kill_nxt;
            if (w_load) begin
                r_instr  <= INSTRUCTION_IN;
                r_imm    <= w_imm_sel;
                r_muldiv <= w_is_muldiv;
            end
        end
    end

`ifdef ILLEGAL_DETECT_EN
    logic w_illegal;
    logic r_illegal;

    assign w_illegal = !(w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                          OP_LOAD, OP_STORE, OP_IMM, OP_REG});

    always_ff @(posedge CLK) begin
        if (RESET)
            r_illegal <= 1'b0;
        else if (w_load)
            r_illegal <= w_illegal;
    end

    assign ILLEGAL_OUT = r_illegal;
`else
    assign ILLEGAL_OUT = 1'b0;
`endif

    assign VALID_OUT       = r_valid;
    assign INSTRUCTION_OUT = r_instr;
    assign IMM_SELECT      = r_imm;
    assign IS_MULDIV       = r_muldiv;
    assign DIV_START       = r_div_start;
    assign DIV_KILL        = r_div_kill;

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

ID-stage controller for the RV32IM pipeline. It accepts fetched instructions over a valid/ready handshake, decodes the opcode into the 4-bit immediate-format select consumed by the immediate generator, and registers the result toward EX. It also sequences fixed-latency M-extension divides by issuing the divider start pulse and holding the pipeline while the divide runs.

## Interface
- DIV_LATENCY, 32: divider cycles from start to result valid; legal range 2..63.
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- INSTRUCTION_IN  input  32  fetched instruction.
- VALID_IN  input  1  INSTRUCTION_IN is valid.
- READY_OUT  output  1  block can accept this cycle (combinational).
- FLUSH  input  1  synchronous kill of the registered instruction and any divide in progress.
- READY_IN  input  1  EX can accept the registered instruction.
- VALID_OUT  output  1  registered instruction valid to EX.
- INSTRUCTION_OUT  output  32  registered instruction.
- IMM_SELECT  output  4  immediate format select; bit 3 = zero-extend, bits 2:0 = format.
- IS_MULDIV  output  1  registered instruction is an M-extension op.
- DIV_START  output  1  one-cycle divider start pulse.
- DIV_KILL  output  1  one-cycle divider abort pulse.
- ILLEGAL_OUT  output  1  registered instruction has an unrecognised opcode (see Configuration).

## Operation
- Decode from opcode [6:0]:
  - 0110111/0010111 (LUI/AUIPC) -> 0000.
  - 1101111 (JAL) -> 0001.
  - 0010011 with funct3 001/101 (shifts) -> 0101.
  - 0010011 with other funct3, 0000011 (loads), 1100111 (JALR) -> 0010.
  - 1100011 (branches) -> 0011.
  - 0100011 (stores) -> 0100.
  - 0110011 (R-type and M-extension) and all others -> 0111.
  - Bit 3 is driven 0 for every RV32IM opcode.
- IS_MULDIV is 1 for opcode 0110011 with funct7 0000001. A divide is an M-extension op with funct3[2]=1 (DIV/DIVU/REM/REMU).
- States: RUN and DIV_WAIT, with a 6-bit down-counter CNT.
- RUN:
  - READY_OUT = READY_IN | ~VALID_OUT.
  - Accept when VALID_IN & READY_OUT. Register the instruction and its decode.
  - On accepting a non-divide: VALID_OUT <= 1.
  - On accepting a divide: VALID_OUT <= 0, DIV_START <= 1, CNT <= DIV_LATENCY-1, go to DIV_WAIT.
  - Without an accept, VALID_OUT <= VALID_OUT & ~READY_IN.
- DIV_WAIT:
  - READY_OUT = 0. DIV_START returns to 0. CNT decrements each edge.
  - On the edge where CNT==0: VALID_OUT <= 1, go to RUN.
- FLUSH (priority below RESET, above everything else):
  - VALID_OUT <= 0, state <= RUN, CNT <= 0, DIV_START <= 0.
  - DIV_KILL <= 1 for one cycle if state was DIV_WAIT or DIV_START was high.
  - An input offered in the same cycle is dropped.
- RESET values:
  - VALID_OUT 0, INSTRUCTION_OUT 32'h00000013 (NOP), IMM_SELECT 4'b0111.
  - IS_MULDIV 0, DIV_START 0, DIV_KILL 0, ILLEGAL_OUT 0.
  - State RUN, CNT 0.

## Timing
- Non-divide: accepted at edge k, VALID_OUT/decode valid from edge k; one cycle of latency.
- Full throughput of one instruction per cycle while READY_IN=1.
- Back-pressure: with VALID_OUT=1 and READY_IN=0, all outputs hold and READY_OUT=0.
- Divide: accepted at edge k. DIV_START is high for the cycle following edge k only. VALID_OUT rises at edge k+DIV_LATENCY. No accept is possible before that edge.
- A divide accepted while an older instruction is being consumed is legal: the older one leaves at edge k.
- FLUSH and RESET take effect at the same edge they are sampled. There are no partial states.

## Configuration
- ILLEGAL_DETECT_EN:
  - Defined: opcodes outside the list above set ILLEGAL_OUT with VALID_OUT; IMM_SELECT=0111 and the instruction passes unmodified.
  - Undefined: ILLEGAL_OUT is tied 0 and no detection logic is built.

## Test plan
- Reset, then ADDI x1,x0,5 (32'h00500093) with READY_IN=1 -> next edge VALID_OUT=1, IMM_SELECT=0010, IS_MULDIV=0.
- Stream LUI, JAL, BEQ, SW, SRAI back-to-back -> IMM_SELECT 0000, 0001, 0011, 0100, 0101 on consecutive cycles; READY_OUT stays 1.
- READY_IN=0 for 3 cycles with VALID_OUT=1 -> INSTRUCTION_OUT stable, READY_OUT=0, new VALID_IN ignored; resumes the cycle READY_IN returns to 1.
- DIV x3,x1,x2 (32'h0220C1B3), DIV_LATENCY=4 -> DIV_START high one cycle after accept; VALID_OUT rises exactly 4 edges after accept; READY_OUT=0 throughout.
- FLUSH 2 cycles into that divide -> DIV_KILL one-cycle pulse, VALID_OUT=0, state RUN, READY_OUT=1 the next cycle.
- With ILLEGAL_DETECT_EN defined, opcode 1111111 -> ILLEGAL_OUT=1, IMM_SELECT=0111; with the macro undefined -> ILLEGAL_OUT=0.
